// File: rtl/snn_pkg.sv
// Shared types and default widths for the spike output path.
package snn_pkg;

  localparam int unsigned NUM_PE_DEF     = 16;
  localparam int unsigned ADDR_W_DEF     = $clog2(NUM_PE_DEF);
  localparam int unsigned TS_W_DEF       = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  // One address-event word as carried to the spike router.
  typedef struct packed {
    logic                  eot;
    logic                  layer;
    logic [TS_W_DEF-1:0]   ts;
    logic [ADDR_W_DEF-1:0] addr;
  } aer_event_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EOT  = 2'd2
  } state_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous event FIFO; head entry comes straight from the register array.
module spike_event_fifo
  import snn_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  aer_event_t push_data,
  input  logic       pop,
  output aer_event_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  aer_event_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Flags come from the registered count, so a same-cycle pop never frees room for a push.
  always_comb begin
    full    = (count == (PTR_W+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises each timestep's PE spike vector into AER words followed by an EOT marker.
// Struct field widths come from snn_pkg; keep NUM_PE/ADDR_W/TS_W at the package defaults.
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_PE     = NUM_PE_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned TS_W       = TS_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PE-1:0] spike_vec,
  input  logic              layer,
  input  logic              ts_end,
  output logic              capture_ready,
  output logic              aer_valid,
  input  logic              aer_ready,
  output logic [ADDR_W-1:0] aer_addr,
  output logic              aer_layer,
  output logic [TS_W-1:0]   aer_ts,
  output logic              aer_eot,
  output logic              overflow,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [NUM_PE-1:0] pending;
  logic [NUM_PE-1:0] pending_nxt;
  logic [NUM_PE-1:0] pending_rest;
  logic              lyr_q;
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   ts_cnt;
  logic              accept;
  logic              push;
  aer_event_t        push_data;
  aer_event_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  // Index of the lowest set bit; ascending scan order.
  function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_PE-1:0] v);
    logic [ADDR_W-1:0] idx;
    logic              found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (v[i] && !found) begin
        idx   = ADDR_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Next-state, capture and push decisions.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    pending_rest  = pending & (pending - 1'b1);
    capture_ready = 1'b0;
    accept        = 1'b0;
    push          = 1'b0;
    push_data     = '0;
    case (state)
      IDLE: begin
        capture_ready = 1'b1;
        if (ts_end) begin
          accept      = 1'b1;
          pending_nxt = spike_vec;
          state_nxt   = (spike_vec == '0) ? EOT : SCAN;
        end
      end
      SCAN: begin
        if (!fifo_full) begin
          push        = 1'b1;
          push_data   = '{eot: 1'b0, layer: lyr_q, ts: ts_q, addr: lowest_set(pending)};
          pending_nxt = pending_rest;
          if (pending_rest == '0) state_nxt = EOT;
        end
      end
      EOT: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = '{eot: 1'b1, layer: lyr_q, ts: ts_q, addr: '0};
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, captured timestep context and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= '0;
      lyr_q    <= 1'b0;
      ts_q     <= '0;
      ts_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (accept) begin
        lyr_q  <= layer;
        ts_q   <= ts_cnt;
        ts_cnt <= ts_cnt + 1'b1;
      end
      if (ts_end && !capture_ready) overflow <= 1'b1;
    end
  end

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stream outputs from the FIFO head.
  always_comb begin
    aer_valid = !fifo_empty;
    pop       = aer_valid && aer_ready;
    aer_addr  = head.addr;
    aer_layer = head.layer;
    aer_ts    = head.ts;
    aer_eot   = head.eot;
    busy      = (state != IDLE) || aer_valid;
  end

endmodule
